shift_cmd_sequencer: RTL and testbench
======================================

Name: shift_cmd_sequencer

Overview:
Upstream sequencer for the team's 8-bit combinational shifter (ports i, n, lr, ar, rot; output o).
- Accepts shift commands over a valid/ready interface and buffers them in a small FIFO.
- Presents one normalised command at a time to the shifter, registers the shifter result, and returns it over a valid/ready result interface.
- Decouples the producer and consumer from the shifter's combinational path and adds a zero flag.

Parameters:
DEPTH, 4, command FIFO depth (power of two, >=2)
CNT_W, 16, width of the optional statistics counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  FIFO can accept; equals not full
cmd_data  input  8  operand
cmd_n  input  4  shift amount 0..15
cmd_lr  input  1  1 = left, 0 = right
cmd_ar  input  1  arithmetic select
cmd_rot  input  1  rotate select (overrides ar)
sh_i  output  8  operand to shifter
sh_n  output  4  normalised amount to shifter
sh_lr / sh_ar / sh_rot  output  1 each  control to shifter
sh_o  input  8  shifter result (combinational from sh_*)
res_valid  output  1  result held
res_ready  input  1  consumer accepts
res_data  output  8  registered result
res_zero  output  1  res_data == 0
busy  output  1  FIFO non-empty or res_valid
stat_cnt  output  CNT_W  completed results (only with feature)

Behaviour:
- Reset (async, any cycle, including mid-operation): FIFO pointers and count = 0, res_valid = 0, res_data = 0, res_zero = 1, stat_cnt = 0. In-flight commands are discarded. cmd_ready = 1 after reset release.
- Enqueue: on an edge with cmd_valid && cmd_ready, write {data, n, lr, ar, rot} at wr_ptr. Pointers wrap modulo DEPTH. Count uses log2(DEPTH)+1 bits.
- Full: cmd_ready = 0 and cmd_valid is ignored. Producer must hold data while cmd_ready = 0.
- sh_* always reflects the FIFO head, normalised as follows:
  - rot = 1: sh_n = {1'b0, n[2:0]}, sh_ar = 0.
  - rot = 0 and n >= 8: sh_n = 8. Logical shift yields 0. Arithmetic right yields sign fill. Arithmetic left yields 0.
  - otherwise sh_n = n.
  - When the FIFO is empty, drive sh_* = 0.
- Result slot states:
  - EMPTY (res_valid = 0) -> FULL when FIFO non-empty: capture sh_o into res_data, compute res_zero, pop head.
  - FULL -> FULL with a new capture when res_ready = 1 and FIFO non-empty (back-to-back, one result per cycle).
  - FULL -> EMPTY when res_ready = 1 and FIFO empty.
  - FULL with res_ready = 0: hold res_data and pop nothing.
- Issue condition: FIFO non-empty && (!res_valid || res_ready).
- Latency: a command accepted on edge t into an empty FIFO with an EMPTY slot gives res_valid = 1 after edge t+1. Throughput is 1 per cycle.
- Simultaneous push and pop in one edge: count unchanged. Pushing while full is never allowed, even if a pop occurs on the same edge (cmd_ready depends on count only).
- Result ordering strictly follows acceptance order.
- busy = (count != 0) || res_valid.

Optional Feature:
SHSEQ_STATS_EN
- Defined: stat_cnt increments by 1 on every result handshake (res_valid && res_ready) and wraps at 2^CNT_W. Reset value is 0.
- Undefined: the stat_cnt port is absent and no counter logic is generated.

Test Plan:
- Reset mid-stream with 3 commands queued and res_valid = 1: assert rst asynchronously between edges -> res_valid = 0, cmd_ready = 1, busy = 0 immediately. No stale results appear afterwards.
- Single command data=0x96, n=3, right, ar=1 -> sh_n = 3 one cycle after accept. res_data = 0xF2, res_zero = 0, res_valid high after edge t+1.
- Normalisation:
  - data=0x81, n=10, rot=1, left -> sh_n = 2.
  - data=0x81, n=12, logical left -> sh_n = 8, res_data = 0x00, res_zero = 1.
  - data=0x81, n=9, arithmetic right -> res_data = 0xFF.
- Fill to DEPTH=4 with res_ready = 0 -> after 4 accepts plus 1 capture, cmd_ready = 0 and a 6th cmd_valid is held. Releasing res_ready -> 5 results in order, one per cycle.
- Streaming with cmd_valid and res_ready held high for 20 commands -> 20 results in order, no bubbles after the first. With SHSEQ_STATS_EN defined, stat_cnt = 20.
- Random res_ready backpressure (50%) over 100 commands against a reference model -> all results match, none lost or duplicated.

Source files
------------

// File: rtl/shift_cmd_sequencer.sv
// Command FIFO and registered result slot in front of the team's 8-bit combinational shifter.
// Define SHSEQ_STATS_EN to add the stat_cnt port counting completed result handshakes.
module shift_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  input  logic [3:0] cmd_n,
  input  logic       cmd_lr,
  input  logic       cmd_ar,
  input  logic       cmd_rot,
  output logic [7:0] sh_i,
  output logic [3:0] sh_n,
  output logic       sh_lr,
  output logic       sh_ar,
  output logic       sh_rot,
  input  logic [7:0] sh_o,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_zero,
  output logic       busy
`ifdef SHSEQ_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 15;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (CNT_W < 1)) begin : g_param_check
    $error("shift_cmd_sequencer: DEPTH must be a power of two >= 2 and CNT_W >= 1");
  end

  typedef enum logic [0:0] {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_e;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  slot_e         slot_q, slot_d;
  logic [7:0]    res_data_q, res_data_d;
  logic          res_zero_q, res_zero_d;
  logic          fifo_empty, push, pop;
  logic [EW-1:0] head;
  logic [7:0]    head_data;
  logic [3:0]    head_n;
  logic          head_lr, head_ar, head_rot;

  assign fifo_empty = (count_q == {(AW+1){1'b0}});
  assign cmd_ready  = (count_q != FULL_CNT);
  assign push       = cmd_valid && cmd_ready;
  assign head       = mem_q[rd_ptr_q];
  assign {head_data, head_n, head_lr, head_ar, head_rot} = head;
  assign res_data   = res_data_q;
  assign res_zero   = res_zero_q;
  assign busy       = !fifo_empty || res_valid;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {cmd_data, cmd_n, cmd_lr, cmd_ar, cmd_rot};
      wr_ptr_d        = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1'b1);
      2'b01:   count_d = count_q - (AW+1)'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // Rotations only use n mod 8 and never sign-fill; plain shifts of 8 or more saturate at 8.
  always_comb begin
    sh_i   = 8'h00;
    sh_n   = 4'd0;
    sh_lr  = 1'b0;
    sh_ar  = 1'b0;
    sh_rot = 1'b0;
    if (fifo_empty) begin
      sh_i = 8'h00;
    end else if (head_rot) begin
      sh_i   = head_data;
      sh_n   = {1'b0, head_n[2:0]};
      sh_lr  = head_lr;
      sh_rot = 1'b1;
    end else if (head_n[3]) begin
      sh_i  = head_data;
      sh_n  = 4'd8;
      sh_lr = head_lr;
      sh_ar = head_ar;
    end else begin
      sh_i  = head_data;
      sh_n  = head_n;
      sh_lr = head_lr;
      sh_ar = head_ar;
    end
  end

  always_comb begin
    slot_d = slot_q;
    case (slot_q)
      SLOT_EMPTY: slot_d = fifo_empty ? SLOT_EMPTY : SLOT_FULL;
      SLOT_FULL:  slot_d = (res_ready && fifo_empty) ? SLOT_EMPTY : SLOT_FULL;
      default:    slot_d = SLOT_EMPTY;
    endcase
  end

  // A new result is captured whenever the slot is free or being drained this cycle.
  always_comb begin
    res_valid  = 1'b0;
    pop        = 1'b0;
    res_data_d = res_data_q;
    res_zero_d = res_zero_q;
    case (slot_q)
      SLOT_EMPTY: pop = !fifo_empty;
      SLOT_FULL: begin
        res_valid = 1'b1;
        pop       = !fifo_empty && res_ready;
      end
      default: pop = 1'b0;
    endcase
    if (pop) begin
      res_data_d = sh_o;
      res_zero_d = (sh_o == 8'h00);
    end else begin
      res_data_d = res_data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= {EW{1'b0}};
      end
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {(AW+1){1'b0}};
      slot_q     <= SLOT_EMPTY;
      res_data_q <= 8'h00;
      res_zero_q <= 1'b1;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      slot_q     <= slot_d;
      res_data_q <= res_data_d;
      res_zero_q <= res_zero_d;
    end
  end

`ifdef SHSEQ_STATS_EN
  logic [CNT_W-1:0] stat_cnt_q, stat_cnt_d;

  always_comb begin
    if (res_valid && res_ready) begin
      stat_cnt_d = stat_cnt_q + CNT_W'(1'b1);
    end else begin
      stat_cnt_d = stat_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stat_cnt_q <= stat_cnt_d;
    end
  end

  assign stat_cnt = stat_cnt_q;
`endif

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Self-checking bench for shift_cmd_sequencer: models the downstream shifter and predicts
// every result bit-by-bit from the raw command, independent of the sequencer's normalisation.
module tb_shift_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_data = 8'h00;
  logic [3:0] cmd_n = 4'd0;
  logic       cmd_lr = 1'b0, cmd_ar = 1'b0, cmd_rot = 1'b0;
  logic [7:0] sh_i;
  logic [3:0] sh_n;
  logic       sh_lr, sh_ar, sh_rot;
  logic [7:0] sh_o;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       res_zero;
  logic       busy;
`ifdef SHSEQ_STATS_EN
  logic [CNT_W-1:0] stat_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];

  shift_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_n(cmd_n),
    .cmd_lr(cmd_lr), .cmd_ar(cmd_ar), .cmd_rot(cmd_rot),
    .sh_i(sh_i), .sh_n(sh_n), .sh_lr(sh_lr), .sh_ar(sh_ar), .sh_rot(sh_rot), .sh_o(sh_o),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_zero(res_zero),
    .busy(busy)
`ifdef SHSEQ_STATS_EN
    , .stat_cnt(stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  // The team's shifter: combinational, amount 0..8.
  function automatic logic [7:0] shifter_model(input logic [7:0] i, input logic [3:0] n,
                                               input logic lr, input logic ar, input logic rot);
    logic [15:0] w;
    if (rot) begin
      if (lr) begin
        w = {i, i} << n[2:0];
        return w[15:8];
      end else begin
        w = {i, i} >> n[2:0];
        return w[7:0];
      end
    end else if (lr) begin
      w = {8'h00, i} << n;
      return w[7:0];
    end else if (ar) begin
      w = {{8{i[7]}}, i} >> n;
      return w[7:0];
    end else begin
      return i >> n;
    end
  endfunction

  assign sh_o = shifter_model(sh_i, sh_n, sh_lr, sh_ar, sh_rot);

  // Expected result straight from the command's meaning, one output bit at a time.
  function automatic logic [7:0] ref_result(input logic [14:0] c);
    logic [7:0] d;
    logic [7:0] o;
    int n, s, src;
    d = c[14:7];
    n = int'(c[6:3]);
    o = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (c[0]) begin
        s = n % 8;
        src = c[2] ? (k - s + 8) % 8 : (k + s) % 8;
        o[k] = d[src];
      end else if (c[2]) begin
        o[k] = (k - n >= 0) ? d[k - n] : 1'b0;
      end else begin
        o[k] = (k + n <= 7) ? d[k + n] : (c[1] ? d[7] : 1'b0);
      end
    end
    return o;
  endfunction

  // Called at posedge+1; drives one cycle and reports the handshakes that occur at the next edge.
  task automatic drive_cycle(input logic v, input logic [14:0] cmd, input logic rr,
                             output logic acc, output logic got,
                             output logic [7:0] rdata, output logic rzero);
    cmd_valid = v;
    {cmd_data, cmd_n, cmd_lr, cmd_ar, cmd_rot} = cmd;
    res_ready = rr;
    #1;
    acc   = v && cmd_ready;
    got   = res_valid && rr;
    rdata = res_data;
    rzero = res_zero;
    if (acc) exp_q.push_back(ref_result(cmd));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (res_data !== 8'h00) begin errors++; $display("FAIL reset_res_data: got %h want 00", res_data); end
    checks++; if (res_zero !== 1'b1) begin errors++; $display("FAIL reset_res_zero: got %b want 1", res_zero); end
    checks++; if ({sh_i, sh_n, sh_lr, sh_ar, sh_rot} !== 15'h0000) begin errors++; $display("FAIL reset_sh: got %h/%0d want 0", sh_i, sh_n); end
`ifdef SHSEQ_STATS_EN
    checks++; if (stat_cnt !== 16'd0) begin errors++; $display("FAIL reset_stat: got %0d want 0", stat_cnt); end
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset_midstream();
    logic acc, got, rz;
    logic [7:0] rd;
    int stale;
    for (int k = 0; k < 4; k++) drive_cycle(1'b1, 15'($urandom), 1'b0, acc, got, rd, rz);
    checks++; if (res_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL mid_pre: got valid=%b busy=%b want 1/1", res_valid, busy); end
    cmd_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_res_valid: got %b want 0", res_valid); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      drive_cycle(1'b0, 15'h0000, 1'b1, acc, got, rd, rz);
      if (got) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL mid_stale: got %0d results want 0", stale); end
  endtask

  task automatic test_single();
    logic acc, got, rz;
    logic [7:0] rd, e;
    drive_cycle(1'b1, {8'h96, 4'd3, 1'b0, 1'b1, 1'b0}, 1'b0, acc, got, rd, rz);
    checks++; if (sh_n !== 4'd3 || sh_i !== 8'h96) begin errors++; $display("FAIL single_sh: got i=%h n=%0d want 96/3", sh_i, sh_n); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_early: got valid=%b want 0", res_valid); end
    drive_cycle(1'b0, 15'h0000, 1'b0, acc, got, rd, rz);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", res_valid); end
    checks++; if (res_data !== 8'hF2 || res_zero !== 1'b0) begin errors++; $display("FAIL single_data: got %h z=%b want F2 z=0", res_data, res_zero); end
    drive_cycle(1'b0, 15'h0000, 1'b1, acc, got, rd, rz);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (got !== 1'b1 || rd !== e) begin errors++; $display("FAIL single_hs: got hs=%b data=%h want 1/%h", got, rd, e); end
  endtask

  task automatic test_normalise();
    logic acc, got, rz;
    logic [7:0] rd, e;
    logic [14:0] tcmd [5];
    logic [3:0]  tshn [5];
    logic        tshar [5];
    logic [7:0]  tres [5];
    tcmd  = '{{8'h81, 4'd10, 1'b1, 1'b0, 1'b1}, {8'h81, 4'd12, 1'b1, 1'b0, 1'b0},
              {8'h81, 4'd9, 1'b0, 1'b1, 1'b0}, {8'h81, 4'd9, 1'b1, 1'b1, 1'b1},
              {8'h81, 4'd7, 1'b0, 1'b0, 1'b0}};
    tshn  = '{4'd2, 4'd8, 4'd8, 4'd1, 4'd7};
    tshar = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tres  = '{8'h06, 8'h00, 8'hFF, 8'h03, 8'h01};
    for (int t = 0; t < 5; t++) begin
      drive_cycle(1'b1, tcmd[t], 1'b0, acc, got, rd, rz);
      checks++; if (sh_n !== tshn[t] || sh_ar !== tshar[t]) begin errors++; $display("FAIL norm%0d_sh: got n=%0d ar=%b want %0d/%b", t, sh_n, sh_ar, tshn[t], tshar[t]); end
      drive_cycle(1'b0, 15'h0000, 1'b0, acc, got, rd, rz);
      checks++; if (res_valid !== 1'b1 || res_data !== tres[t]) begin errors++; $display("FAIL norm%0d_data: got v=%b %h want 1/%h", t, res_valid, res_data, tres[t]); end
      checks++; if (res_zero !== (tres[t] == 8'h00)) begin errors++; $display("FAIL norm%0d_zero: got %b want %b", t, res_zero, tres[t] == 8'h00); end
      drive_cycle(1'b0, 15'h0000, 1'b1, acc, got, rd, rz);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++; if (got !== 1'b1 || rd !== e) begin errors++; $display("FAIL norm%0d_hs: got hs=%b %h want 1/%h", t, got, rd, e); end
    end
  endtask

  task automatic test_fill();
    logic acc, got, rz;
    logic [7:0] rd, e;
    logic [14:0] c [6];
    int idx, gots, total;
    for (int k = 0; k < 6; k++) c[k] = 15'($urandom);
    idx = 0;
    for (int k = 0; k < 10; k++) begin
      drive_cycle(1'b1, c[(idx < 6) ? idx : 5], 1'b0, acc, got, rd, rz);
      if (acc) idx++;
    end
    checks++; if (idx !== 5) begin errors++; $display("FAIL fill_accepts: got %0d want 5", idx); end
    checks++; if (cmd_ready !== 1'b0 || res_valid !== 1'b1) begin errors++; $display("FAIL fill_full: got ready=%b valid=%b want 0/1", cmd_ready, res_valid); end
    gots = 0;
    total = 0;
    for (int k = 0; k < 30 && (total < 6); k++) begin
      drive_cycle(idx < 6, c[(idx < 6) ? idx : 5], 1'b1, acc, got, rd, rz);
      if (acc) idx++;
      if (got) begin
        total++;
        if (k < 5) gots++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (rd !== e || rz !== (e == 8'h00)) begin errors++; $display("FAIL fill_order%0d: got %h z=%b want %h", total, rd, rz, e); end
      end
    end
    checks++; if (gots !== 5) begin errors++; $display("FAIL fill_rate: got %0d results in 5 cycles want 5", gots); end
    checks++; if (total !== 6 || exp_q.size() !== 0) begin errors++; $display("FAIL fill_total: got %0d left %0d want 6/0", total, exp_q.size()); end
  endtask

  task automatic test_stream();
    logic acc, got, rz;
    logic [7:0] rd, e;
    logic [14:0] c;
    int idx, results, bubbles;
    do_reset();
    idx = 0;
    results = 0;
    bubbles = 0;
    c = 15'($urandom);
    for (int k = 0; k < 80 && (results < 20); k++) begin
      drive_cycle(idx < 20, c, 1'b1, acc, got, rd, rz);
      if (acc) begin idx++; c = 15'($urandom); end
      if (got) begin
        results++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (rd !== e || rz !== (e == 8'h00)) begin errors++; $display("FAIL stream_data%0d: got %h z=%b want %h", results, rd, rz, e); end
      end else if (results > 0) begin
        bubbles++;
      end
    end
    checks++; if (results !== 20) begin errors++; $display("FAIL stream_count: got %0d want 20", results); end
    checks++; if (bubbles !== 0) begin errors++; $display("FAIL stream_bubbles: got %0d want 0", bubbles); end
`ifdef SHSEQ_STATS_EN
    checks++; if (stat_cnt !== 16'd20) begin errors++; $display("FAIL stream_stat: got %0d want 20", stat_cnt); end
`endif
  endtask

  task automatic test_random_backpressure();
    logic acc, got, rz, offering;
    logic [7:0] rd, e;
    logic [14:0] c;
    int idx, results;
    idx = 0;
    results = 0;
    offering = 1'b0;
    c = 15'h0000;
    for (int k = 0; k < 3000 && (results < 100); k++) begin
      if (!offering && idx < 100 && $urandom_range(0, 99) < 70) begin
        offering = 1'b1;
        c = 15'($urandom);
      end
      drive_cycle(offering, c, 1'($urandom_range(0, 1)), acc, got, rd, rz);
      if (acc) begin idx++; offering = 1'b0; end
      if (got) begin
        results++;
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL rand_extra: got %h want no result", rd);
        end else begin
          e = exp_q.pop_front();
          checks++; if (rd !== e || rz !== (e == 8'h00)) begin errors++; $display("FAIL rand_data%0d: got %h z=%b want %h", results, rd, rz, e); end
        end
      end
    end
    checks++; if (idx !== 100 || results !== 100) begin errors++; $display("FAIL rand_count: got acc=%0d res=%0d want 100/100", idx, results); end
    checks++; if (exp_q.size() !== 0 || busy !== 1'b0) begin errors++; $display("FAIL rand_idle: got left=%0d busy=%b want 0/0", exp_q.size(), busy); end
  endtask

  initial begin
    test_reset();
    test_reset_midstream();
    test_single();
    test_normalise();
    test_fill();
    test_stream();
    test_random_backpressure();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
